rc5_seq_ctrl: RTL and testbench

RC5_SEQ_CTRL -- requirements
Module: rc5_seq_ctrl

---
 rtl/rc5_seq_ctrl.sv | 154 +++++++++++++++
 tb/tb_rc5_seq_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc5_seq_ctrl.sv
// rc5_seq_ctrl: sequences one 64-bit job at a time through an RC5 encoder/decoder core pair.
// Define RC5_SEQ_SELFCHECK_EN to decrypt every ciphertext again and flag mismatches on out_err.
module rc5_seq_ctrl #(
  parameter int ROUNDS = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_mode,
  input  logic [63:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        out_mode,
  output logic        out_err,
  output logic        busy,
  output logic        enc_rst,
  output logic        dec_rst,
  output logic [63:0] enc_din,
  output logic [63:0] dec_din,
  input  logic [63:0] enc_dout,
  input  logic [63:0] dec_dout
);
  localparam logic [7:0] LAST = 8'(ROUNDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
`ifdef RC5_SEQ_SELFCHECK_EN
    CHK_LOAD,
    CHK_RUN,
`endif
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q;
  logic [63:0] data_q;
  logic        mode_q;
  logic [63:0] res_q;
  logic        omode_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = LOAD;
      LOAD: state_d = RUN;
      RUN: if (cnt_q == LAST) begin
`ifdef RC5_SEQ_SELFCHECK_EN
        state_d = mode_q ? DONE : CHK_LOAD;
`else
        state_d = DONE;
`endif
      end
`ifdef RC5_SEQ_SELFCHECK_EN
      CHK_LOAD: state_d = CHK_RUN;
      CHK_RUN: if (cnt_q == LAST) state_d = DONE;
`endif
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Idle core is parked in reset with a zero input so it never toggles.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    enc_rst   = 1'b0;
    dec_rst   = 1'b0;
    enc_din   = '0;
    dec_din   = '0;
    case (state_q)
      LOAD: begin
        if (mode_q) dec_din = data_q;
        else        enc_din = data_q;
      end
      RUN: begin
        if (mode_q) begin
          dec_rst = 1'b1;
          dec_din = data_q;
        end else begin
          enc_rst = 1'b1;
          enc_din = data_q;
        end
      end
`ifdef RC5_SEQ_SELFCHECK_EN
      CHK_LOAD: dec_din = res_q;
      CHK_RUN: begin
        dec_rst = 1'b1;
        dec_din = res_q;
      end
`endif
      default: ;
    endcase
  end

  assign busy     = ~in_ready;
  assign out_data = res_q;
  assign out_mode = omode_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      mode_q  <= 1'b0;
      res_q   <= '0;
      omode_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (in_valid) begin
          data_q <= in_data;
          mode_q <= in_mode;
          cnt_q  <= '0;
        end
        LOAD: cnt_q <= '0;
        RUN: begin
          if (cnt_q == LAST) begin
            res_q   <= mode_q ? dec_dout : enc_dout;
            omode_q <= mode_q;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
`ifdef RC5_SEQ_SELFCHECK_EN
        CHK_LOAD: cnt_q <= '0;
        CHK_RUN: if (cnt_q != LAST) cnt_q <= cnt_q + 8'd1;
`endif
        default: ;
      endcase
    end
  end

`ifdef RC5_SEQ_SELFCHECK_EN
  logic err_q;

  // res_q still holds the ciphertext during the check, so out_data is the encrypt result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (cnt_q == LAST) begin
      if (state_q == RUN)          err_q <= 1'b0;
      else if (state_q == CHK_RUN) err_q <= (dec_dout != data_q);
    end
  end

  assign out_err = err_q;
`else
  assign out_err = 1'b0;
`endif
endmodule

// File: tb/tb_rc5_seq_ctrl.sv
// Scoreboard bench for rc5_seq_ctrl: two instances (ROUNDS=12 and ROUNDS=1) with xor-stub cores.
module tb_rc5_seq_ctrl;
  localparam logic [63:0] K = 64'hA5A5A5A5A5A5A5A5;

  typedef struct {
    logic [63:0] data;
    logic        mode;
    logic        err;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic        in_valid[2];
  logic        in_mode[2];
  logic [63:0] in_data[2];
  logic        flip[2];
  int          rdy_mode[2];

  wire         in_ready[2], out_valid[2], out_mode[2], out_err[2], busy[2];
  wire         enc_rst[2], dec_rst[2];
  wire  [63:0] out_data[2], enc_din[2], dec_din[2], enc_dout[2], dec_dout[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int R = (g == 0) ? 12 : 1;
    logic [7:0] ec = 8'd0;
    logic [7:0] dc = 8'd0;
    logic       ordy = 1'b0;
    bit         prev_v = 1'b0;
    bit         cur_mode = 1'b0;
    int         acc_cyc = 0;
    exp_t       q[$];

    rc5_seq_ctrl #(.ROUNDS(R)) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]), .in_mode(in_mode[g]), .in_data(in_data[g]),
      .out_valid(out_valid[g]), .out_ready(ordy), .out_data(out_data[g]), .out_mode(out_mode[g]),
      .out_err(out_err[g]), .busy(busy[g]),
      .enc_rst(enc_rst[g]), .dec_rst(dec_rst[g]), .enc_din(enc_din[g]), .dec_din(dec_din[g]),
      .enc_dout(enc_dout[g]), .dec_dout(dec_dout[g])
    );

    // Stub cores: transparent in reset, garbage until R run cycles elapsed, then din ^ K.
    always @(posedge clk) begin
      ec <= enc_rst[g] ? ((ec == 8'hFF) ? ec : ec + 8'd1) : 8'd0;
      dc <= dec_rst[g] ? ((dc == 8'hFF) ? dc : dc + 8'd1) : 8'd0;
    end
    assign enc_dout[g] = !enc_rst[g] ? enc_din[g] :
                         (ec >= 8'(R - 1)) ? (enc_din[g] ^ K) : ~enc_din[g];
    assign dec_dout[g] = !dec_rst[g] ? dec_din[g] :
                         (dc >= 8'(R - 1)) ? (dec_din[g] ^ K ^ {63'd0, flip[g]}) : ~dec_din[g];

    always @(posedge clk) begin
      #1;
      case (rdy_mode[g])
        0:       ordy = ($urandom_range(0, 3) != 0);
        1:       ordy = 1'b0;
        default: ordy = 1'b1;
      endcase
    end

    // Reference model: push the expected result at the accept edge.
    always @(posedge clk) begin
      if (rst && in_valid[g] && in_ready[g]) begin
        exp_t e;
        e.mode = in_mode[g];
        e.data = in_data[g] ^ K;
        e.err  = 1'b0;
        e.lat  = R + 2;
        if (in_mode[g]) e.data[0] = e.data[0] ^ flip[g];
`ifdef RC5_SEQ_SELFCHECK_EN
        if (!in_mode[g]) begin
          e.lat = 2 * R + 3;
          e.err = flip[g];
        end
`endif
        q.push_back(e);
        acc_cyc  = cyc;
        cur_mode = in_mode[g];
      end
    end

    always @(negedge rst) q.delete();

    always @(negedge clk) begin
      if (rst) begin
        if (busy[g] && cur_mode) begin
          chk($sformatf("dut%0d_enc_parked_rst", g), 64'(enc_rst[g]), 64'd0);
          chk($sformatf("dut%0d_enc_parked_din", g), enc_din[g], 64'd0);
        end
`ifndef RC5_SEQ_SELFCHECK_EN
        if (busy[g] && !cur_mode) begin
          chk($sformatf("dut%0d_dec_parked_rst", g), 64'(dec_rst[g]), 64'd0);
          chk($sformatf("dut%0d_dec_parked_din", g), dec_din[g], 64'd0);
        end
`endif
        if (out_valid[g]) begin
          chk($sformatf("dut%0d_in_ready_in_done", g), 64'(in_ready[g]), 64'd0);
          chk($sformatf("dut%0d_busy_in_done", g), 64'(busy[g]), 64'd1);
          if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL dut%0d_unexpected_out_valid: got out_valid=1 want no pending job", g);
          end else begin
            if (!prev_v) chk($sformatf("dut%0d_latency", g), 64'(cyc - acc_cyc), 64'(q[0].lat));
            chk($sformatf("dut%0d_out_data", g), out_data[g], q[0].data);
            chk($sformatf("dut%0d_out_mode", g), 64'(out_mode[g]), 64'(q[0].mode));
            chk($sformatf("dut%0d_out_err", g), 64'(out_err[g]), 64'(q[0].err));
            if (ordy) void'(q.pop_front());
          end
        end
        prev_v = out_valid[g];
      end else begin
        prev_v = 1'b0;
      end
    end
  end

  function automatic int qsize(input int g);
    return (g == 0) ? g_dut[0].q.size() : g_dut[1].q.size();
  endfunction

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got timeout want event", name);
  endtask

  // Call at posedge+#1; returns at posedge+#1 after the accept edge with junk on the inputs.
  task automatic submit(input int g, input logic [63:0] d, input logic m);
    int t = 0;
    in_valid[g] = 1'b1;
    in_data[g]  = d;
    in_mode[g]  = m;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready[g] && t < 500);
    if (t >= 500) timeout($sformatf("dut%0d_accept", g));
    @(posedge clk);
    #1;
    in_valid[g] = 1'b0;
    in_data[g]  = {$urandom, $urandom};
    in_mode[g]  = 1'($urandom);
  endtask

  task automatic drain(input int g);
    int t = 0;
    while ((qsize(g) != 0 || out_valid[g]) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) timeout($sformatf("dut%0d_drain", g));
    @(posedge clk);
    #1;
  endtask

  task automatic rand_jobs(input int g, input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      submit(g, {$urandom, $urandom}, 1'($urandom));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    for (int g = 0; g < 2; g++) begin
      in_valid[g] = 1'b0;
      in_mode[g]  = 1'b0;
      in_data[g]  = '0;
      flip[g]     = 1'b0;
      rdy_mode[g] = 2;
    end

    #12;
    chk("rst_in_ready", 64'(in_ready[0]), 64'd1);
    chk("rst_out_valid", 64'(out_valid[0]), 64'd0);
    chk("rst_out_data", out_data[0], 64'd0);
    chk("rst_out_mode", 64'(out_mode[0]), 64'd0);
    chk("rst_out_err", 64'(out_err[0]), 64'd0);
    chk("rst_busy", 64'(busy[0]), 64'd0);
    chk("rst_core_rst", {62'd0, enc_rst[0], dec_rst[0]}, 64'd0);
    chk("rst_core_din", enc_din[0] | dec_din[0], 64'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("post_rst_in_ready", 64'(in_ready[0]), 64'd1);
    @(posedge clk);
    #1;

    submit(0, 64'h0123456789ABCDEF, 1'b0);
    drain(0);
    submit(0, 64'hA48620CC2C0E684A, 1'b1);
    drain(0);
    submit(1, 64'h0123456789ABCDEF, 1'b0);
    drain(1);
    submit(1, 64'hFEDCBA9876543210, 1'b1);
    drain(1);

    // Abandon a job mid-RUN with an asynchronous reset.
    submit(0, {$urandom, $urandom}, 1'b0);
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid[0]), 64'd0);
    chk("midrst_in_ready", 64'(in_ready[0]), 64'd1);
    chk("midrst_busy", 64'(busy[0]), 64'd0);
    chk("midrst_core_rst", {62'd0, enc_rst[0], dec_rst[0]}, 64'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (30) @(negedge clk);
    @(posedge clk);
    #1;

    rdy_mode[0] = 0;
    rdy_mode[1] = 0;
    fork
      rand_jobs(0, 30);
      rand_jobs(1, 40);
    join
    drain(0);
    drain(1);

    // Backpressure with a second job waiting on the input.
    rdy_mode[0] = 1;
    @(posedge clk);
    #1;
    submit(0, {$urandom, $urandom}, 1'b0);
    in_valid[0] = 1'b1;
    in_data[0]  = {$urandom, $urandom};
    in_mode[0]  = 1'b1;
    t = 0;
    while (!out_valid[0] && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) timeout("bp_out_valid");
    repeat (20) @(negedge clk);
    rdy_mode[0] = 2;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(out_valid[0] && g_dut[0].ordy) && t < 50);
    if (t >= 50) timeout("bp_handshake");
    @(negedge clk);
    chk("bp_in_ready_after_hs", 64'(in_ready[0]), 64'd1);
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    in_data[0]  = {$urandom, $urandom};
    drain(0);

`ifdef RC5_SEQ_SELFCHECK_EN
    flip[0] = 1'b1;
    submit(0, {$urandom, $urandom}, 1'b0);
    drain(0);
    flip[0] = 1'b0;
    submit(0, {$urandom, $urandom}, 1'b0);
    drain(0);
`endif

    rdy_mode[0] = 2;
    rdy_mode[1] = 2;
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
